// File: rtl/sarray_row_feeder_pkg.sv
// Shared widths, PE protocol encodings and feeder state encodings for the
// systolic-array left-edge feeders.
package sarray_row_feeder_pkg;

    localparam int SARRAY_W             = 4;
    localparam int SARRAY_H             = 4;
    localparam int TMMA_CNT_WIDTH       = 6;
    localparam int TMMA_PRECISION_WIDTH = 3;
    localparam int PE_INPUT_DATA_WIDTH  = 16;

    localparam logic PE_DATA_TYPE_A = 1'b0;
    localparam logic PE_DATA_TYPE_C = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_ARMED  = 3'd2,
        ST_SKEW   = 3'd3,
        ST_STREAM = 3'd4
    } feeder_state_e;

    // One bit wider than the cnt field so that a length of exactly 2**CNT_WIDTH fits.
    function automatic logic [TMMA_CNT_WIDTH:0] stream_len(
        input logic                      is_c,
        input logic [TMMA_CNT_WIDTH-1:0] req,
        input int                        max_k
    );
        logic [TMMA_CNT_WIDTH:0] req_w;
        req_w = {1'b0, req};
        if (is_c)
            return (TMMA_CNT_WIDTH+1)'(SARRAY_W);
        if (int'(req_w) > max_k)
            return (TMMA_CNT_WIDTH+1)'(max_k);
        return req_w;
    endfunction

endpackage

// File: rtl/sarray_row_feeder_buf.sv
// Operand word buffer for one feeder: single write port, combinational read
// port addressed by the stream counter. Contents are deliberately not reset.
module sarray_row_feeder_buf
    import sarray_row_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [PE_INPUT_DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                  raddr,
    output logic [PE_INPUT_DATA_WIDTH-1:0] rdata
);

    logic [PE_INPUT_DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH))
            mem[waddr] <= wdata;
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/sarray_row_feeder.sv
// Left-edge transmitter for one systolic-array row: buffers a command's operand
// words, then streams them into PE(0,ROW) ROW cycles after the shared start pulse.
//
//   state     | meaning
//   ST_IDLE   | waiting for a command; cmd_ready_o high
//   ST_FILL   | accepting len operand words; wr_ready_o high
//   ST_ARMED  | buffer full, waiting for start_i
//   ST_SKEW   | down-counting ROW cycles of row skew
//   ST_STREAM | one beat per cycle until len beats are out
module sarray_row_feeder
    import sarray_row_feeder_pkg::*;
#(
    parameter int ROW   = 0,
    parameter int MAX_K = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_type_i,
    input  logic [TMMA_CNT_WIDTH-1:0]       cmd_len_i,
    input  logic [TMMA_PRECISION_WIDTH-1:0] cmd_precision_i,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [PE_INPUT_DATA_WIDTH-1:0]  wr_data_i,
    input  logic                            start_i,
    output logic                            left_data_valid_o,
    output logic [TMMA_CNT_WIDTH-1:0]       left_data_cnt_o,
    output logic                            left_data_type_o,
    output logic [TMMA_PRECISION_WIDTH-1:0] left_precision_o,
    output logic [PE_INPUT_DATA_WIDTH-1:0]  left_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            start_err_o
);

    localparam int CW = TMMA_CNT_WIDTH;
    localparam int PW = TMMA_PRECISION_WIDTH;
    localparam int DW = PE_INPUT_DATA_WIDTH;
    localparam int LW = CW + 1;
    localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int SW = (ROW > 1) ? $clog2(ROW) : 1;

    if (MAX_K > (1 << TMMA_CNT_WIDTH) || MAX_K < SARRAY_W) begin : g_bad_cfg
        $error("sarray_row_feeder: MAX_K must lie in [SARRAY_W, 2**TMMA_CNT_WIDTH]");
    end

    feeder_state_e  state;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  fill_idx;
    logic [LW-1:0]  beat_idx;
    logic [SW-1:0]  skew_cnt;
    logic           type_q;
    logic [PW-1:0]  prec_q;

    logic           cmd_fire;
    logic           wr_fire;
    logic [LW-1:0]  cmd_len;
    logic [LW-1:0]  beat_sel;
    logic [CW-1:0]  beat_cnt;
    logic [DW-1:0]  rd_data;

    assign cmd_fire = cmd_valid_i & cmd_ready_o;
    assign wr_fire  = wr_valid_i & wr_ready_o;
    assign cmd_len  = stream_len(cmd_type_i, cmd_len_i, MAX_K);

    // Beat 0 is launched from ARMED/SKEW, later beats from STREAM at beat_idx.
    assign beat_sel = (state == ST_STREAM) ? beat_idx : '0;
    assign beat_cnt = (type_q == PE_DATA_TYPE_C) ? CW'(SARRAY_W) - CW'(beat_sel)
                                                 : CW'(beat_sel);

    sarray_row_feeder_buf #(
        .DEPTH (MAX_K),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (AW'(fill_idx)),
        .wdata (wr_data_i),
        .raddr (AW'(beat_sel)),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            len_q             <= '0;
            fill_idx          <= '0;
            beat_idx          <= '0;
            skew_cnt          <= '0;
            type_q            <= 1'b0;
            prec_q            <= '0;
            cmd_ready_o       <= 1'b0;
            wr_ready_o        <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            start_err_o       <= 1'b0;
            left_data_valid_o <= 1'b0;
            left_data_cnt_o   <= '0;
            left_data_type_o  <= 1'b0;
            left_precision_o  <= '0;
            left_data_o       <= '0;
        end else begin
            left_data_valid_o <= 1'b0;
            left_data_cnt_o   <= '0;
            left_data_type_o  <= 1'b0;
            left_precision_o  <= '0;
            left_data_o       <= '0;
            done_o            <= 1'b0;

            if (start_i && (state != ST_ARMED))
                start_err_o <= 1'b1;

            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_fire) begin
                        type_q   <= cmd_type_i;
                        prec_q   <= cmd_precision_i;
                        len_q    <= cmd_len;
                        fill_idx <= '0;
                        if (cmd_len == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state       <= ST_FILL;
                            cmd_ready_o <= 1'b0;
                            wr_ready_o  <= 1'b1;
                            busy_o      <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (wr_fire) begin
                        fill_idx <= fill_idx + 1'b1;
                        if (fill_idx == len_q - 1'b1) begin
                            state      <= ST_ARMED;
                            wr_ready_o <= 1'b0;
                        end
                    end
                end

                ST_ARMED: begin
                    if (start_i) begin
                        if (ROW == 0) begin
                            left_data_valid_o <= 1'b1;
                            left_data_cnt_o   <= beat_cnt;
                            left_data_type_o  <= type_q;
                            left_precision_o  <= prec_q;
                            left_data_o       <= rd_data;
                            beat_idx          <= LW'(1);
                            state             <= ST_STREAM;
                        end else begin
                            skew_cnt <= SW'(ROW - 1);
                            state    <= ST_SKEW;
                        end
                    end
                end

                ST_SKEW: begin
                    if (skew_cnt == '0) begin
                        left_data_valid_o <= 1'b1;
                        left_data_cnt_o   <= beat_cnt;
                        left_data_type_o  <= type_q;
                        left_precision_o  <= prec_q;
                        left_data_o       <= rd_data;
                        beat_idx          <= LW'(1);
                        state             <= ST_STREAM;
                    end else begin
                        skew_cnt <= skew_cnt - 1'b1;
                    end
                end

                ST_STREAM: begin
                    if (beat_idx == len_q) begin
                        state       <= ST_IDLE;
                        done_o      <= 1'b1;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end else begin
                        left_data_valid_o <= 1'b1;
                        left_data_cnt_o   <= beat_cnt;
                        left_data_type_o  <= type_q;
                        left_precision_o  <= prec_q;
                        left_data_o       <= rd_data;
                        beat_idx          <= beat_idx + 1'b1;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    busy_o      <= 1'b0;
                    wr_ready_o  <= 1'b0;
                    cmd_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sarray_row_feeder.sv
// Scoreboard bench for sarray_row_feeder with ROW=2, MAX_K=16: expected beats are
// queued when start_i is driven and checked against the left-edge outputs.
module tb_sarray_row_feeder;
    import sarray_row_feeder_pkg::*;

    localparam int ROW   = 2;
    localparam int MAX_K = 16;
    localparam int CW    = TMMA_CNT_WIDTH;
    localparam int PW    = TMMA_PRECISION_WIDTH;
    localparam int DW    = PE_INPUT_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_type_i;
    logic [CW-1:0] cmd_len_i;
    logic [PW-1:0] cmd_precision_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [DW-1:0] wr_data_i;
    logic          start_i;
    logic          left_data_valid_o;
    logic [CW-1:0] left_data_cnt_o;
    logic          left_data_type_o;
    logic [PW-1:0] left_precision_o;
    logic [DW-1:0] left_data_o;
    logic          busy_o;
    logic          done_o;
    logic          start_err_o;

    sarray_row_feeder #(.ROW(ROW), .MAX_K(MAX_K)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_type_i        (cmd_type_i),
        .cmd_len_i         (cmd_len_i),
        .cmd_precision_i   (cmd_precision_i),
        .wr_valid_i        (wr_valid_i),
        .wr_ready_o        (wr_ready_o),
        .wr_data_i         (wr_data_i),
        .start_i           (start_i),
        .left_data_valid_o (left_data_valid_o),
        .left_data_cnt_o   (left_data_cnt_o),
        .left_data_type_o  (left_data_type_o),
        .left_precision_o  (left_precision_o),
        .left_data_o       (left_data_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .start_err_o       (start_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [CW-1:0] cnt;
        logic          typ;
        logic [PW-1:0] prec;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         b;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            beats_seen = 0;
    logic [DW-1:0] pe_col [SARRAY_W];

    // Scoreboard and a PE-row model that captures C beats by their cnt tag.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (left_data_valid_o) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: cyc=%0d cnt=%0d data=%0d, required no beat",
                             cyc, left_data_cnt_o, left_data_o);
                end else begin
                    b = exp_q.pop_front();
                    if (cyc !== b.at || left_data_cnt_o !== b.cnt || left_data_type_o !== b.typ ||
                        left_precision_o !== b.prec || left_data_o !== b.data) begin
                        n_fail++;
                        $display("FAIL beat: got cyc=%0d cnt=%0d type=%0d prec=%0d data=%0d, required cyc=%0d cnt=%0d type=%0d prec=%0d data=%0d",
                                 cyc, left_data_cnt_o, left_data_type_o, left_precision_o, left_data_o,
                                 b.at, b.cnt, b.typ, b.prec, b.data);
                    end
                end
                if (left_data_type_o == PE_DATA_TYPE_C)
                    for (int x = 0; x < SARRAY_W; x++)
                        if (int'(left_data_cnt_o) == SARRAY_W - x) pe_col[x] = left_data_o;
            end else if (left_data_cnt_o !== '0 || left_data_type_o !== 1'b0 ||
                         left_precision_o !== '0 || left_data_o !== '0) begin
                n_fail++;
                $display("FAIL idle_fields: cnt=%0d type=%0d prec=%0d data=%0d, required all 0",
                         left_data_cnt_o, left_data_type_o, left_precision_o, left_data_o);
            end
        end
    end

    task automatic issue_cmd(input logic typ, input int len, input logic [PW-1:0] prec,
                             output int fire_cyc);
        int guard = 0;
        @(posedge clk); #1;
        while (!cmd_ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: cmd_ready_o=%b, required 1", cmd_ready_o);
        end
        cmd_valid_i     = 1'b1;
        cmd_type_i      = typ;
        cmd_len_i       = CW'(len);
        cmd_precision_i = prec;
        fire_cyc        = cyc;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        cmd_len_i   = '0;
    endtask

    task automatic write_words(input int base, input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 200) begin
            @(posedge clk); #1;
            wr_valid_i = 1'b1;
            wr_data_i  = DW'(base + sent);
            if (wr_ready_o) sent++;
            guard++;
        end
        @(posedge clk); #1;
        wr_valid_i = 1'b0;
        n_checks++;
        if (sent != n) begin
            n_fail++;
            $display("FAIL write_words: accepted=%0d, required %0d", sent, n);
        end
    endtask

    task automatic start_and_expect(input logic typ, input int n, input int base,
                                    input logic [PW-1:0] prec, output int t);
        beat_t e;
        @(posedge clk); #1;
        start_i = 1'b1;
        t = cyc;
        for (int i = 0; i < n; i++) begin
            e.at   = t + 1 + ROW + i;
            e.cnt  = (typ == PE_DATA_TYPE_C) ? CW'(SARRAY_W - i) : CW'(i);
            e.typ  = typ;
            e.prec = prec;
            e.data = DW'(base + i);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                dc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready_o, wr_ready_o, busy_o, done_o, start_err_o, left_data_valid_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b wr_ready=%b busy=%b done=%b err=%b valid=%b, required all 0",
                     cmd_ready_o, wr_ready_o, busy_o, done_o, start_err_o, left_data_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready_o=%b busy_o=%b, required 1/0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_a_stream();
        int f, t, dc;
        bit ok;
        issue_cmd(PE_DATA_TYPE_A, 4, 3'd5, f);
        write_words(10, 4);
        n_checks++;
        if (wr_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL a_armed: wr_ready_o=%b busy_o=%b, required 0/1", wr_ready_o, busy_o);
        end
        start_and_expect(PE_DATA_TYPE_A, 4, 10, 3'd5, t);
        wait_done(dc, ok);
        n_checks++;
        if (!ok || dc != t + 7) begin
            n_fail++;
            $display("FAIL a_done: done cycle=%0d, required %0d", dc, t + 7);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL a_beats_left: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_c_preload();
        int f, t, dc;
        bit ok;
        for (int x = 0; x < SARRAY_W; x++) pe_col[x] = '0;
        issue_cmd(PE_DATA_TYPE_C, 7, 3'd2, f);
        write_words(20, SARRAY_W);
        start_and_expect(PE_DATA_TYPE_C, SARRAY_W, 20, 3'd2, t);
        wait_done(dc, ok);
        n_checks++;
        if (!ok || dc != t + 1 + ROW + SARRAY_W) begin
            n_fail++;
            $display("FAIL c_done: done cycle=%0d, required %0d", dc, t + 1 + ROW + SARRAY_W);
        end
        for (int x = 0; x < SARRAY_W; x++) begin
            n_checks++;
            if (pe_col[x] !== DW'(20 + x)) begin
                n_fail++;
                $display("FAIL c_pe_col%0d: captured=%0d, required %0d", x, pe_col[x], 20 + x);
            end
        end
    endtask

    task automatic test_len_zero();
        int f;
        issue_cmd(PE_DATA_TYPE_A, 0, 3'd1, f);
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b1 || cyc != f + 1) begin
            n_fail++;
            $display("FAIL len0_done: done_o=%b at cyc=%0d, required 1 at %0d", done_o, cyc, f + 1);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_ready_o !== 1'b0 || busy_o !== 1'b0 || (i > 0 && done_o !== 1'b0)) begin
                n_fail++;
                $display("FAIL len0_idle: wr_ready_o=%b busy_o=%b done_o=%b, required 0/0/0",
                         wr_ready_o, busy_o, done_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        int f, t, dc;
        bit ok;
        issue_cmd(PE_DATA_TYPE_A, 40, 3'd7, f);
        write_words(30, MAX_K);
        n_checks++;
        if (wr_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_wr_ready: wr_ready_o=%b after %0d writes, required 0", wr_ready_o, MAX_K);
        end
        wr_valid_i = 1'b1;
        wr_data_i  = DW'(99);
        @(negedge clk);
        n_checks++;
        if (wr_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_extra_word: wr_ready_o=%b busy_o=%b, required 0/1", wr_ready_o, busy_o);
        end
        @(posedge clk); #1;
        wr_valid_i = 1'b0;
        start_and_expect(PE_DATA_TYPE_A, MAX_K, 30, 3'd7, t);
        wait_done(dc, ok);
        n_checks++;
        if (!ok || dc != t + 1 + ROW + MAX_K) begin
            n_fail++;
            $display("FAIL clamp_done: done cycle=%0d, required %0d", dc, t + 1 + ROW + MAX_K);
        end
    endtask

    task automatic test_start_err();
        int f, t, dc;
        bit ok;
        n_checks++;
        if (start_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before: start_err_o=%b, required 0", start_err_o);
        end
        issue_cmd(PE_DATA_TYPE_A, 3, 3'd4, f);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (start_err_o !== 1'b1 || wr_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_fill_start: start_err_o=%b wr_ready_o=%b, required 1/1", start_err_o, wr_ready_o);
        end
        write_words(40, 3);
        start_and_expect(PE_DATA_TYPE_A, 3, 40, 3'd4, t);
        wait_done(dc, ok);
        n_checks++;
        if (!ok || dc != t + 1 + ROW + 3 || start_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_second_start: done cycle=%0d err=%b, required %0d/1", dc, start_err_o, t + 1 + ROW + 3);
        end
    endtask

    task automatic test_reset_mid();
        int f, t, base, guard;
        issue_cmd(PE_DATA_TYPE_A, 8, 3'd6, f);
        write_words(50, 8);
        start_and_expect(PE_DATA_TYPE_A, 8, 50, 3'd6, t);
        base  = beats_seen;
        guard = 0;
        while (beats_seen < base + 3 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (beats_seen < base + 3) begin
            n_fail++;
            $display("FAIL mid_beats: seen=%0d, required %0d", beats_seen - base, 3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({left_data_valid_o, busy_o, done_o, start_err_o, cmd_ready_o, wr_ready_o} !== 6'b0 ||
            left_data_cnt_o !== '0 || left_data_o !== '0 || left_precision_o !== '0 || left_data_type_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: valid=%b busy=%b err=%b cnt=%0d data=%0d, required all 0",
                     left_data_valid_o, busy_o, start_err_o, left_data_cnt_o, left_data_o);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || start_err_o !== 1'b0 || left_data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: ready=%b busy=%b err=%b valid=%b, required 1/0/0/0",
                     cmd_ready_o, busy_o, start_err_o, left_data_valid_o);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        cmd_valid_i     = 1'b0;
        cmd_type_i      = 1'b0;
        cmd_len_i       = '0;
        cmd_precision_i = '0;
        wr_valid_i      = 1'b0;
        wr_data_i       = '0;
        start_i         = 1'b0;
        test_reset();
        test_a_stream();
        test_c_preload();
        test_len_zero();
        test_clamp();
        test_start_err();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
